// File: rtl/dwt_fp_pkg.sv
// Shared FP32 definitions for the DWT multiplier/divider datapath:
// field widths, field-extract helpers and the divider state encoding.
package dwt_fp_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned MAN_W   = 23;
  localparam int unsigned FP_W    = 1 + EXP_W + MAN_W;
  localparam int unsigned SEXP_W  = 10;
  localparam int unsigned FP_BIAS = 127;
  localparam int unsigned EXP_MAX = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } div_state_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  typedef struct packed {
    logic exception;
    logic overflow;
    logic underflow;
    logic div_by_zero;
  } fp_flags_t;

  // Significand with hidden bit; exponent 0 flushes to zero
  function automatic logic [MAN_W:0] fp_sig(input fp32_t x);
    return {|x.exp, x.man};
  endfunction

  function automatic logic fp_exp_special(input fp32_t x);
    return &x.exp;
  endfunction

  function automatic logic fp_exp_zero(input fp32_t x);
    return ~|x.exp;
  endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// Combinational round-to-nearest-even and FP32 result/flag selection
// for a normalised quotient (or product) with special-case overrides.
module fp32_round_pack
  import dwt_fp_pkg::*;
(
  input  logic                     i_sign,
  input  logic signed [SEXP_W-1:0] i_exp,
  input  logic [MAN_W-1:0]         i_man,
  input  logic                     i_guard,
  input  logic                     i_sticky,
  input  logic                     i_exc,
  input  logic                     i_b_zero,
  input  logic                     i_a_zero,
  output logic [FP_W-1:0]          o_result_c,
  output fp_flags_t                o_flags_c
);

  localparam logic signed [SEXP_W-1:0] EXP_MAX_S = SEXP_W'(EXP_MAX);
  localparam logic signed [SEXP_W-1:0] ZERO_S    = '0;

  logic                     w_inc;
  logic [MAN_W:0]           w_man_sum;
  logic [MAN_W-1:0]         w_man_rnd;
  logic signed [SEXP_W-1:0] w_exp_rnd;

  assign w_inc     = i_guard & (i_sticky | i_man[0]);
  assign w_man_sum = {1'b0, i_man} + (MAN_W+1)'(w_inc);
  // Mantissa carry-out renormalises before the range checks
  assign w_man_rnd = w_man_sum[MAN_W] ? '0 : w_man_sum[MAN_W-1:0];
  assign w_exp_rnd = i_exp + SEXP_W'(w_man_sum[MAN_W]);

  always_comb begin
    o_result_c = {i_sign, w_exp_rnd[EXP_W-1:0], w_man_rnd};
    o_flags_c  = '0;
    if (i_exc) begin
      o_result_c          = '0;
      o_flags_c.exception = 1'b1;
    end else if (i_b_zero) begin
      o_result_c            = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      o_flags_c.div_by_zero = 1'b1;
    end else if (i_a_zero) begin
      o_result_c = {i_sign, {(FP_W-1){1'b0}}};
    end else if (w_exp_rnd >= EXP_MAX_S) begin
      o_result_c         = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      o_flags_c.overflow = 1'b1;
    end else if (w_exp_rnd <= ZERO_S) begin
      o_result_c          = {i_sign, {(FP_W-1){1'b0}}};
      o_flags_c.underflow = 1'b1;
    end
  end

endmodule

// File: rtl/dwt_divider.sv
// Iterative FP32 divider: radix-2 restoring mantissa division, one quotient
// bit per cycle, valid/ready on both sides, fixed latency for all inputs.
module dwt_divider
  import dwt_fp_pkg::*;
#(
  parameter int unsigned QBITS = 26,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      a_operand,
  input  logic [31:0]      b_operand,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic [TAG_W-1:0] out_tag,
  output logic             Exception,
  output logic             Overflow,
  output logic             Underflow,
  output logic             DivByZero
);

  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned REM_W = SIG_W + 1;
  localparam int unsigned CNT_W = $clog2(QBITS + 1);

  div_state_e r_state;
  div_state_e w_state_next;
  logic       w_accept;

  logic                r_in_ready;
  logic                r_out_valid;
  logic [FP_W-1:0]     r_result;
  logic [TAG_W-1:0]    r_out_tag;
  fp_flags_t           r_flags;

  logic                r_sign;
  logic [EXP_W-1:0]    r_ea;
  logic [EXP_W-1:0]    r_eb;
  logic [SIG_W-1:0]    r_mb;
  logic [REM_W-1:0]    r_rem;
  logic [QBITS-1:0]    r_q;
  logic [CNT_W-1:0]    r_cnt;
  logic [TAG_W-1:0]    r_tag;
  logic                r_exc;
  logic                r_a_zero;
  logic                r_b_zero;

  fp32_t               w_a;
  fp32_t               w_b;
  logic                w_rem_ge;
  logic [REM_W-1:0]    w_rem_sub;
  logic [QBITS-2:0]    w_q_norm;
  logic signed [SEXP_W-1:0] w_exp_norm;
  logic [MAN_W-1:0]    w_man;
  logic                w_guard;
  logic                w_sticky;
  logic [FP_W-1:0]     w_result_c;
  fp_flags_t           w_flags_c;

  assign w_a = a_operand;
  assign w_b = b_operand;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && r_in_ready) begin
          w_accept     = 1'b1;
          w_state_next = DIV;
        end
      end
      DIV:     if (r_cnt == CNT_W'(QBITS - 1)) w_state_next = NORM;
      NORM:    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // One restoring step: subtract divisor when the partial remainder allows
  assign w_rem_ge  = r_rem >= {1'b0, r_mb};
  assign w_rem_sub = w_rem_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

  // Normalise: quotient lies in [0.5, 2) so at most one left shift is needed
  assign w_q_norm   = r_q[QBITS-1] ? r_q[QBITS-2:0] : {r_q[QBITS-3:0], 1'b0};
  assign w_exp_norm = SEXP_W'(r_ea) - SEXP_W'(r_eb)
                    + SEXP_W'(r_q[QBITS-1] ? FP_BIAS : FP_BIAS - 1);
  assign w_man      = w_q_norm[QBITS-2 -: MAN_W];
  assign w_guard    = w_q_norm[QBITS-2-MAN_W];
  assign w_sticky   = (|w_q_norm[QBITS-3-MAN_W:0]) | (|r_rem);

  fp32_round_pack u_round_pack (
    .i_sign     (r_sign),
    .i_exp      (w_exp_norm),
    .i_man      (w_man),
    .i_guard    (w_guard),
    .i_sticky   (w_sticky),
    .i_exc      (r_exc),
    .i_b_zero   (r_b_zero),
    .i_a_zero   (r_a_zero),
    .o_result_c (w_result_c),
    .o_flags_c  (w_flags_c)
  );

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_out_tag   <= '0;
      r_flags     <= '0;
      r_sign      <= 1'b0;
      r_ea        <= '0;
      r_eb        <= '0;
      r_mb        <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_tag       <= '0;
      r_exc       <= 1'b0;
      r_a_zero    <= 1'b0;
      r_b_zero    <= 1'b0;
    end else begin
      r_in_ready <= (w_state_next == IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sign   <= w_a.sign ^ w_b.sign;
            r_ea     <= w_a.exp;
            r_eb     <= w_b.exp;
            r_rem    <= REM_W'(fp_sig(w_a));
            r_mb     <= fp_sig(w_b);
            r_q      <= '0;
            r_cnt    <= '0;
            r_tag    <= in_tag;
            r_exc    <= fp_exp_special(w_a) | fp_exp_special(w_b);
            r_a_zero <= fp_exp_zero(w_a);
            r_b_zero <= fp_exp_zero(w_b);
          end
        end
        DIV: begin
          r_q   <= {r_q[QBITS-2:0], w_rem_ge};
          r_rem <= w_rem_sub << 1;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        NORM: begin
          r_out_valid <= 1'b1;
          r_result    <= w_result_c;
          r_flags     <= w_flags_c;
          r_out_tag   <= r_tag;
        end
        DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign out_tag   = r_out_tag;
  assign Exception = r_flags.exception;
  assign Overflow  = r_flags.overflow;
  assign Underflow = r_flags.underflow;
  assign DivByZero = r_flags.div_by_zero;

endmodule
